// File: rtl/mem_responder_if.sv
// Request/response bus between a core-side master and mem_responder,
// including the TX FIFO drain port and the RX byte source.
interface mem_responder_if;
  logic        wr;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ack;

  modport master (
    output wr, addr, wdata,
    output io_tx_ready, io_rx_data, io_rx_valid,
    input  rdata, io_tx_data, io_tx_valid, io_rx_ack
  );

  modport slave (
    input  wr, addr, wdata,
    input  io_tx_ready, io_rx_data, io_rx_valid,
    output rdata, io_tx_data, io_tx_valid, io_rx_ack
  );
endinterface

// File: rtl/mem_responder.sv
// Byte RAM with a memory-mapped TX FIFO / RX port and a status register.
// The IO region exists only when MEM_RESPONDER_IO_EN is defined.
module mem_responder #(
  parameter int          RAM_ADDR_W = 17,
  parameter logic [31:0] IO_ADDR    = 32'h0003_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  logic [7:0]            mem [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic [7:0]            rdata_q;

  assign ram_idx   = bus.addr[RAM_ADDR_W-1:0];
  assign bus.rdata = rdata_q;

`ifdef MEM_RESPONDER_IO_EN

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic          is_io;
  logic          is_stat;
  logic          is_ram;
  logic          io_wr;
  logic          io_rd;
  logic          prev_wr;
  logic          prev_rd;
  logic          push;
  logic          pop;
  logic          accept;
  logic          full;
  logic          ovf;
  logic          ack_q;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [3:0]    cnt_sat;
  logic [7:0]    status;
  logic [7:0]    fifo [FIFO_DEPTH];

  assign is_io   = bus.addr == IO_ADDR;
  assign is_stat = bus.addr == IO_ADDR + 32'd4;
  assign is_ram  = !is_io && !is_stat;
  assign io_wr   = bus.wr && is_io;
  assign io_rd   = !bus.wr && is_io;

  // Only the first cycle of a held IO store pushes.
  assign push   = io_wr && !prev_wr;
  assign pop    = bus.io_tx_valid && bus.io_tx_ready;
  assign full   = cnt == CW'(FIFO_DEPTH);
  assign accept = push && (!full || pop);

  assign cnt_sat = (32'(cnt) > 32'd15) ? 4'hF : 4'(cnt);
  assign status  = {cnt_sat, 1'b0, ovf,
                    bus.io_rx_valid, full};

  assign bus.io_tx_valid = cnt != '0;
  assign bus.io_tx_data  = fifo[rp];
  assign bus.io_rx_ack   = ack_q;

  always_ff @(posedge clk) begin
    if (bus.wr && is_ram)
      mem[ram_idx] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && accept)
      fifo[wp] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      ack_q   <= 1'b0;
      prev_wr <= 1'b0;
      prev_rd <= 1'b0;
    end else begin
      prev_wr <= io_wr;
      prev_rd <= io_rd;
      ack_q   <= io_rd && !prev_rd
                 && bus.io_rx_valid;
      if (!bus.wr) begin
        unique case (1'b1)
          is_io:   rdata_q <= bus.io_rx_valid
                              ? bus.io_rx_data
                              : 8'h00;
          is_stat: rdata_q <= status;
          default: rdata_q <= mem[ram_idx];
        endcase
      end
      if (pop)
        rp <= rp + PW'(1);
      if (accept)
        wp <= wp + PW'(1);
      if (accept && !pop)
        cnt <= cnt + CW'(1);
      else if (!accept && pop)
        cnt <= cnt - CW'(1);
      // A fresh overflow beats the read-to-clear.
      ovf <= (push && full && !pop)
             || (ovf && !(!bus.wr && is_stat));
    end
  end

`else

  logic unused_io;

  assign unused_io = ^{bus.io_tx_ready,
                       bus.io_rx_data,
                       bus.io_rx_valid,
                       bus.addr[31:RAM_ADDR_W]};

  assign bus.io_tx_valid = 1'b0;
  assign bus.io_tx_data  = 8'h00;
  assign bus.io_rx_ack   = 1'b0;

  always_ff @(posedge clk) begin
    if (bus.wr)
      mem[ram_idx] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else if (!bus.wr)
      rdata_q <= mem[ram_idx];
  end

`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a queue/array model.
// Covers the IO region only when MEM_RESPONDER_IO_EN is defined.
module tb_mem_responder;

  localparam logic [31:0] IO    = 32'h0003_0000;
  localparam int          DEPTH = 8;
  localparam int          AW    = 17;
  localparam logic [31:0] IDLE  = 32'h0000_FFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if bus();

  mem_responder #(
    .RAM_ADDR_W(AW),
    .IO_ADDR   (IO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_m [int];
  logic [7:0] q [$];
  int         wlist [$];
  bit         ovf_m;
  bit         pw_m;
  bit         pr_m;
  logic [7:0] exp_rdata;
  bit         exp_ack;

  task automatic drive(bit w, logic [31:0] a,
                       logic [7:0] d);
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  task automatic idle();
    drive(1'b1, IDLE, 8'h00);
  endtask

  // Apply the behavioural rules to the inputs, then clock.
  task automatic tick();
    bit         io_a;
    bit         st_a;
    bit         pop;
    bit         push;
    bit         ovf_new;
    int         n;
    int         idx;
    logic [7:0] st;
    idx = int'(bus.addr[AW-1:0]);
`ifdef MEM_RESPONDER_IO_EN
    io_a = bus.addr == IO;
    st_a = bus.addr == IO + 32'd4;
`else
    io_a = 1'b0;
    st_a = 1'b0;
`endif
    if (bus.wr && !io_a && !st_a)
      ram_m[idx] = bus.wdata;
    if (rst) begin
      q.delete();
      ovf_m = 0;
      pw_m = 0;
      pr_m = 0;
      exp_rdata = 8'h00;
      exp_ack = 0;
    end else begin
      n = q.size();
      st = {(n > 15) ? 4'hF : 4'(n), 1'b0,
            ovf_m, bus.io_rx_valid, n == DEPTH};
      if (!bus.wr) begin
        if (io_a)
          exp_rdata = bus.io_rx_valid
                      ? bus.io_rx_data : 8'h00;
        else if (st_a)
          exp_rdata = st;
        else if (ram_m.exists(idx) && !bus.wr)
          exp_rdata = ram_m[idx];
        else
          exp_rdata = 8'hxx;
      end
      exp_ack = !bus.wr && io_a
                && bus.io_rx_valid && !pr_m;
      pop  = n > 0 && bus.io_tx_ready;
      push = bus.wr && io_a && !pw_m;
      ovf_new = push && n == DEPTH && !pop;
      if (pop)
        void'(q.pop_front());
      if (push && !ovf_new)
        q.push_back(bus.wdata);
      ovf_m = ovf_new
              || (ovf_m && !(!bus.wr && st_a));
      pw_m = bus.wr && io_a;
      pr_m = !bus.wr && io_a;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ram_addr();
    logic [31:0] a;
    a = $urandom;
    while (a == IO || a == IO + 32'd4
           || a[AW-1:0] == 17'h00100
           || a[AW-1:0] == IDLE[AW-1:0])
      a = $urandom;
    return a;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00",
               bus.rdata);
    end
    checks++;
    if (bus.io_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_txv: got %b want 0",
               bus.io_tx_valid);
    end
    checks++;
    if (bus.io_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0",
               bus.io_rx_ack);
    end
  endtask

  task automatic test_ram_readback();
    drive(1'b1, 32'h100, 8'hA5);
    tick();
    drive(1'b0, 32'h100, 8'h00);
    checks++;
    if (bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL rb_early: got %h want 00",
               bus.rdata);
    end
    tick();
    checks++;
    if (bus.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rb_read: got %h want a5",
               bus.rdata);
    end
    drive(1'b1, 32'h100, 8'h3C);
    tick();
    checks++;
    if (bus.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rb_hold: got %h want a5",
               bus.rdata);
    end
    drive(1'b1, 32'h100, 8'hA5);
    tick();
  endtask

  task automatic test_ram_random();
    logic [31:0] a;
    logic [31:0] r;
    for (int i = 0; i < 120; i++) begin
      if (wlist.size() == 0 || $urandom_range(1) == 0)
      begin
        a = ram_addr();
        wlist.push_back(int'(a));
        drive(1'b1, a, 8'($urandom));
      end else begin
        r = $urandom;
        a = wlist[$urandom_range(wlist.size() - 1)];
        a = {r[31:AW], a[AW-1:0]};
        if (a == IO || a == IO + 32'd4)
          a = a ^ 32'h0010_0000;
        drive(1'b0, a, 8'h00);
      end
      tick();
      if (!$isunknown(exp_rdata)) begin
        checks++;
        if (bus.rdata !== exp_rdata) begin
          errors++;
          $display("FAIL ram_rand: got %h want %h",
                   bus.rdata, exp_rdata);
        end
      end
    end
    idle();
    tick();
  endtask

`ifdef MEM_RESPONDER_IO_EN

  task automatic push_sep(logic [7:0] v);
    drive(1'b1, IO, v);
    tick();
    idle();
    tick();
  endtask

  task automatic test_store_dedupe();
    bus.io_tx_ready = 1'b0;
    drive(1'b1, IO, 8'h41);
    repeat (3) tick();
    idle();
    tick();
    checks++;
    if (bus.io_tx_valid !== 1'b1
        || bus.io_tx_data !== 8'h41) begin
      errors++;
      $display("FAIL dedupe_head: got %b/%h want 1/41",
               bus.io_tx_valid, bus.io_tx_data);
    end
    drive(1'b0, IO + 32'd4, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h10
        || bus.rdata !== exp_rdata) begin
      errors++;
      $display("FAIL dedupe_stat: got %h want 10",
               bus.rdata);
    end
    idle();
    bus.io_tx_ready = 1'b1;
    tick();
    bus.io_tx_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    for (int v = 1; v <= 9; v++)
      push_sep(8'(v));
    drive(1'b0, IO + 32'd4, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h85) begin
      errors++;
      $display("FAIL full_stat: got %h want 85",
               bus.rdata);
    end
    tick();
    checks++;
    if (bus.rdata !== 8'h81) begin
      errors++;
      $display("FAIL ovf_clear: got %h want 81",
               bus.rdata);
    end
    idle();
    bus.io_tx_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      checks++;
      if (bus.io_tx_valid !== 1'b1
          || bus.io_tx_data !== 8'(v)) begin
        errors++;
        $display("FAIL full_pop: got %h want %h",
                 bus.io_tx_data, 8'(v));
      end
      tick();
    end
    checks++;
    if (bus.io_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: got %b want 0",
               bus.io_tx_valid);
    end
    bus.io_tx_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] v;
    bus.io_tx_ready = 1'b0;
    repeat (DEPTH) push_sep(8'($urandom));
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      bus.io_tx_ready = 1'b1;
      drive(1'b1, IO, v);
      checks++;
      if (bus.io_tx_data !== q[0]) begin
        errors++;
        $display("FAIL pp_head: got %h want %h",
                 bus.io_tx_data, q[0]);
      end
      tick();
      bus.io_tx_ready = 1'b0;
      idle();
      tick();
    end
    drive(1'b0, IO + 32'd4, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h81
        || bus.rdata !== exp_rdata) begin
      errors++;
      $display("FAIL pp_stat: got %h want 81",
               bus.rdata);
    end
    idle();
    bus.io_tx_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++)
    begin
      checks++;
      if (bus.io_tx_valid !== 1'b1
          || bus.io_tx_data !== q[0]) begin
        errors++;
        $display("FAIL pp_order: got %h want %h",
                 bus.io_tx_data, q[0]);
      end
      tick();
    end
    checks++;
    if (bus.io_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_drain: got %b want 0",
               bus.io_tx_valid);
    end
    bus.io_tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    bus.io_rx_valid = 1'b1;
    bus.io_rx_data  = 8'h37;
    drive(1'b0, IO, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h37
        || bus.io_rx_ack !== 1'b1) begin
      errors++;
      $display("FAIL rx_first: got %h/%b want 37/1",
               bus.rdata, bus.io_rx_ack);
    end
    tick();
    checks++;
    if (bus.rdata !== 8'h37
        || bus.io_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL rx_held: got %h/%b want 37/0",
               bus.rdata, bus.io_rx_ack);
    end
    drive(1'b0, IO + 32'd4, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h02
        || bus.io_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL rx_stat: got %h/%b want 02/0",
               bus.rdata, bus.io_rx_ack);
    end
    bus.io_rx_valid = 1'b0;
    drive(1'b0, IO, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h00
        || bus.io_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL rx_none: got %h/%b want 00/0",
               bus.rdata, bus.io_rx_ack);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.io_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_sep(8'($urandom));
    checks++;
    if (bus.io_tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_queued: got %b want 1",
               bus.io_tx_valid);
    end
    rst = 1'b1;
    bus.io_tx_ready = 1'b1;
    bus.io_rx_valid = 1'b1;
    drive(1'b0, IO, 8'h00);
    tick();
    rst = 1'b0;
    bus.io_tx_ready = 1'b0;
    bus.io_rx_valid = 1'b0;
    checks++;
    if (bus.io_tx_valid !== 1'b0
        || bus.io_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL rm_clear: got %b/%b want 0/0",
               bus.io_tx_valid, bus.io_rx_ack);
    end
    drive(1'b0, IO + 32'd4, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL rm_stat: got %h want 00",
               bus.rdata);
    end
    drive(1'b0, 32'h100, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rm_ram: got %h want a5",
               bus.rdata);
    end
    idle();
    tick();
  endtask

  task automatic test_random_mix();
    int          op;
    logic [31:0] a;
    op = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) != 0)
        op = $urandom_range(5);
      bus.io_tx_ready = 1'($urandom);
      bus.io_rx_valid = 1'($urandom);
      bus.io_rx_data  = 8'($urandom);
      if (op == 1 && wlist.size() == 0)
        op = 0;
      case (op)
        0: begin
          a = ram_addr();
          wlist.push_back(int'(a));
          drive(1'b1, a, 8'($urandom));
        end
        1: drive(1'b0,
                 wlist[$urandom_range(
                   wlist.size() - 1)], 8'h00);
        2: drive(1'b1, IO, 8'($urandom));
        3: drive(1'b0, IO, 8'h00);
        4: drive(1'b0, IO + 32'd4, 8'h00);
        default: idle();
      endcase
      checks++;
      if (bus.io_tx_valid !== (q.size() > 0)
          || (q.size() > 0
              && bus.io_tx_data !== q[0])) begin
        errors++;
        $display("FAIL mix_tx: got %b/%h want %0d",
                 bus.io_tx_valid, bus.io_tx_data,
                 q.size());
      end
      tick();
      if (!$isunknown(exp_rdata)) begin
        checks++;
        if (bus.rdata !== exp_rdata) begin
          errors++;
          $display("FAIL mix_rdata: got %h want %h",
                   bus.rdata, exp_rdata);
        end
      end
      checks++;
      if (bus.io_rx_ack !== exp_ack) begin
        errors++;
        $display("FAIL mix_ack: got %b want %b",
                 bus.io_rx_ack, exp_ack);
      end
    end
    bus.io_tx_ready = 1'b0;
    bus.io_rx_valid = 1'b0;
    idle();
    tick();
  endtask

`else

  task automatic test_io_disabled();
    bus.io_tx_ready = 1'b1;
    bus.io_rx_valid = 1'b1;
    bus.io_rx_data  = 8'h37;
    drive(1'b1, IO, 8'h5A);
    tick();
    drive(1'b0, IO, 8'h00);
    tick();
    checks++;
    if (bus.rdata !== 8'h5A) begin
      errors++;
      $display("FAIL noio_ram: got %h want 5a",
               bus.rdata);
    end
    checks++;
    if (bus.io_tx_valid !== 1'b0
        || bus.io_tx_data !== 8'h00
        || bus.io_rx_ack !== 1'b0) begin
      errors++;
      $display("FAIL noio_outs: got %b/%h/%b want 0",
               bus.io_tx_valid, bus.io_tx_data,
               bus.io_rx_ack);
    end
    bus.io_tx_ready = 1'b0;
    bus.io_rx_valid = 1'b0;
    idle();
    tick();
  endtask

`endif

  initial begin
    bus.io_tx_ready = 1'b0;
    bus.io_rx_valid = 1'b0;
    bus.io_rx_data  = 8'h00;
    idle();
    #1;
    test_reset();
    test_ram_readback();
`ifdef MEM_RESPONDER_IO_EN
    test_store_dedupe();
    test_fifo_full();
    test_push_pop_full();
    test_rx();
    test_reset_mid();
    test_ram_random();
    test_random_mix();
`else
    test_io_disabled();
    test_ram_random();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
